// File: rtl/l2_request_arbiter.sv
// Arbitrates L1 instruction-cache line requests onto a single L2 port and broadcasts the returned line.
// Optional macro L2ARB_SPEC_EN adds next-line speculative prefetch as the lowest-priority class.
module l2_request_arbiter #(
  parameter int NUM_THREADS = 4,
  parameter int TID_BITS    = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_THREADS-1:0]    br_req,
  input  logic [NUM_THREADS-1:0]    req_refill,
  input  logic [NUM_THREADS-1:0]    req_spec,
  input  logic [NUM_THREADS*32-1:0] req_addr,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [31:0]               mem_req_addr,
  output logic [TID_BITS-1:0]       mem_req_tid,
  input  logic                      mem_rsp_valid,
  input  logic [127:0]              mem_rsp_data,
  output logic [31:0]               l2addr,
  output logic [TID_BITS-1:0]       l2_tid,
  output logic [127:0]              l2_line,
  output logic                      l2_valid_rsp,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RSP} state_t;

  state_t                state_reg, state_next;
  logic [TID_BITS-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [TID_BITS-1:0]   tid_reg, tid_next;
  logic [31:0]           addr_reg, addr_next;
  logic [31:0]           l2addr_reg, l2addr_next;
  logic [TID_BITS-1:0]   l2_tid_reg, l2_tid_next;
  logic [127:0]          l2_line_reg, l2_line_next;

  logic [27:0]           line_thr [NUM_THREADS];
  logic [NUM_THREADS*4-1:0] low_bits;
  logic [NUM_THREADS-1:0] class_vec;
  logic                  grant_found;
  logic [TID_BITS-1:0]   grant_tid;
  logic [TID_BITS-1:0]   grant_rr;
  logic [31:0]           grant_addr;
  logic                  unused_bits;

  // Only the line number of each fetch address matters; the byte offset is dropped.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_THREADS; gi++) begin : g_thr
      assign line_thr[gi]          = req_addr[32*gi+4 +: 28];
      assign low_bits[4*gi +: 4]   = req_addr[32*gi +: 4];
    end
  endgenerate

`ifdef L2ARB_SPEC_EN
  logic is_spec;
  assign unused_bits = ^low_bits;
`else
  assign unused_bits = ^{low_bits, req_spec};
`endif

  always_comb begin
    class_vec = '0;
`ifdef L2ARB_SPEC_EN
    is_spec = 1'b0;
`endif
    if (|br_req)
      class_vec = br_req;
    else if (|req_refill)
      class_vec = req_refill;
`ifdef L2ARB_SPEC_EN
    else if (|req_spec) begin
      class_vec = req_spec;
      is_spec   = 1'b1;
    end
`endif
  end

  // Scan downward so the candidate closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    grant_found = 1'b0;
    grant_tid   = '0;
    for (int k = NUM_THREADS - 1; k >= 0; k--) begin
      int idx;
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_THREADS)
        idx = idx - NUM_THREADS;
      if (class_vec[idx]) begin
        grant_found = 1'b1;
        grant_tid   = TID_BITS'(idx);
      end
    end
  end

  always_comb begin
    int nxt;
    nxt = int'(grant_tid) + 1;
    if (nxt >= NUM_THREADS)
      nxt = 0;
    grant_rr   = TID_BITS'(nxt);
    grant_addr = {line_thr[grant_tid], 4'b0000};
`ifdef L2ARB_SPEC_EN
    if (is_spec)
      grant_addr = {line_thr[grant_tid] + 28'd1, 4'b0000};
`endif
  end

  always_comb begin
    state_next   = state_reg;
    rr_ptr_next  = rr_ptr_reg;
    tid_next     = tid_reg;
    addr_next    = addr_reg;
    l2addr_next  = l2addr_reg;
    l2_tid_next  = l2_tid_reg;
    l2_line_next = l2_line_reg;
    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          tid_next    = grant_tid;
          addr_next   = grant_addr;
          rr_ptr_next = grant_rr;
          state_next  = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_req_ready)
          state_next = WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          l2_line_next = mem_rsp_data;
          l2addr_next  = addr_reg;
          l2_tid_next  = tid_reg;
          state_next   = RSP;
        end
      end
      RSP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      rr_ptr_reg  <= '0;
      tid_reg     <= '0;
      addr_reg    <= '0;
      l2addr_reg  <= '0;
      l2_tid_reg  <= '0;
      l2_line_reg <= '0;
    end else begin
      state_reg   <= state_next;
      rr_ptr_reg  <= rr_ptr_next;
      tid_reg     <= tid_next;
      addr_reg    <= addr_next;
      l2addr_reg  <= l2addr_next;
      l2_tid_reg  <= l2_tid_next;
      l2_line_reg <= l2_line_next;
    end
  end

  assign mem_req_valid = (state_reg == ISSUE);
  assign mem_req_addr  = addr_reg;
  assign mem_req_tid   = tid_reg;
  assign l2_valid_rsp  = (state_reg == RSP);
  assign l2addr        = l2addr_reg;
  assign l2_tid        = l2_tid_reg;
  assign l2_line       = l2_line_reg;
  assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Scoreboard bench for l2_request_arbiter: directed scenarios followed by randomized transactions.
module tb_l2_request_arbiter;
  localparam int N = 4;

`ifdef L2ARB_SPEC_EN
  localparam bit SPEC_EN = 1'b1;
`else
  localparam bit SPEC_EN = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   br_req, req_refill, req_spec;
  logic [N*32-1:0] req_addr;
  logic           mem_req_valid, mem_req_ready;
  logic [31:0]    mem_req_addr;
  logic [1:0]     mem_req_tid;
  logic           mem_rsp_valid;
  logic [127:0]   mem_rsp_data;
  logic [31:0]    l2addr;
  logic [1:0]     l2_tid;
  logic [127:0]   l2_line;
  logic           l2_valid_rsp, busy;

  l2_request_arbiter #(.NUM_THREADS(N), .TID_BITS(2)) dut (
    .clock(clock), .reset(reset),
    .br_req(br_req), .req_refill(req_refill), .req_spec(req_spec), .req_addr(req_addr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_tid(mem_req_tid),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .l2addr(l2addr), .l2_tid(l2_tid), .l2_line(l2_line),
    .l2_valid_rsp(l2_valid_rsp), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct { logic [1:0] tid; logic [31:0] addr; } req_t;
  typedef struct { logic [1:0] tid; logic [31:0] addr; logic [127:0] line; } rsp_t;
  req_t exp_req[$];
  rsp_t exp_rsp[$];

  int n_checks = 0;
  int n_fail   = 0;
  int m_rr     = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference arbitration: highest non-empty class, then first requester at or after the shared pointer.
  task automatic model_grant(input logic [N-1:0] br, input logic [N-1:0] rf, input logic [N-1:0] sp,
                             input logic [N*32-1:0] ad, output bit found, output int tid,
                             output logic [31:0] a);
    logic [N-1:0] v;
    logic [31:0]  line;
    bit           spec;
    found = 0; tid = 0; a = 0; spec = 0;
    if (br != 0) v = br;
    else if (rf != 0) v = rf;
    else if (SPEC_EN && sp != 0) begin v = sp; spec = 1; end
    else return;
    for (int k = 0; k < N; k++) begin
      int t;
      t = (m_rr + k) % N;
      if (v[t]) begin tid = t; found = 1; break; end
    end
    line = ad[32*tid +: 32] >> 4;
    if (spec) line = line + 1;
    a = line << 4;
    m_rr = (tid + 1) % N;
  endtask

  // Monitor: all DUT outputs sampled on the falling edge.
  bit          pend;
  logic [31:0] pend_addr;
  logic [1:0]  pend_tid;
  logic [31:0] last_addr;
  logic [1:0]  last_tid;
  logic [127:0] last_line;

  always @(negedge clock) begin
    if (reset) begin
      pend = 0; last_addr = 0; last_tid = 0; last_line = 0;
    end else begin
      if (pend) begin
        chk("req_hold_valid", 128'(mem_req_valid), 128'(1));
        chk("req_hold_addr", 128'(mem_req_addr), 128'(pend_addr));
        chk("req_hold_tid", 128'(mem_req_tid), 128'(pend_tid));
      end
      if (mem_req_valid && mem_req_ready) begin
        if (exp_req.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_req: got tid %0d addr %h, expected none", mem_req_tid, mem_req_addr);
        end else begin
          req_t e;
          e = exp_req.pop_front();
          chk("req_tid", 128'(mem_req_tid), 128'(e.tid));
          chk("req_addr", 128'(mem_req_addr), 128'(e.addr));
          $display("req  tid=%0d addr=%h", mem_req_tid, mem_req_addr);
        end
      end
      pend = mem_req_valid && !mem_req_ready;
      pend_addr = mem_req_addr;
      pend_tid = mem_req_tid;
      if (l2_valid_rsp) begin
        if (exp_rsp.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_rsp: got tid %0d addr %h, expected none", l2_tid, l2addr);
        end else begin
          rsp_t r;
          r = exp_rsp.pop_front();
          chk("rsp_tid", 128'(l2_tid), 128'(r.tid));
          chk("rsp_addr", 128'(l2addr), 128'(r.addr));
          chk("rsp_line", l2_line, r.line);
          $display("rsp  tid=%0d addr=%h line=%h", l2_tid, l2addr, l2_line);
        end
      end else begin
        chk("l2addr_hold", 128'(l2addr), 128'(last_addr));
        chk("l2_tid_hold", 128'(l2_tid), 128'(last_tid));
        chk("l2_line_hold", l2_line, last_line);
      end
      last_addr = l2addr; last_tid = l2_tid; last_line = l2_line;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_reqs();
    br_req = '0; req_refill = '0; req_spec = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_mem_req_valid"}, 128'(mem_req_valid), 128'(0));
    chk({tag, "_mem_req_addr"}, 128'(mem_req_addr), 128'(0));
    chk({tag, "_mem_req_tid"}, 128'(mem_req_tid), 128'(0));
    chk({tag, "_l2_valid_rsp"}, 128'(l2_valid_rsp), 128'(0));
    chk({tag, "_l2addr"}, 128'(l2addr), 128'(0));
    chk({tag, "_l2_tid"}, 128'(l2_tid), 128'(0));
    chk({tag, "_l2_line"}, l2_line, 128'(0));
  endtask

  task automatic run_txn(input logic [N-1:0] br, input logic [N-1:0] rf, input logic [N-1:0] sp,
                         input logic [N*32-1:0] ad, input int rdy_delay, input int rsp_delay,
                         input bit stray);
    bit          found;
    int          tid;
    logic [31:0] a;
    logic [127:0] d;
    br_req = br; req_refill = rf; req_spec = sp; req_addr = ad;
    model_grant(br, rf, sp, ad, found, tid, a);
    if (!found) begin
      repeat (3) begin
        tick();
        chk("no_grant_valid", 128'(mem_req_valid), 128'(0));
        chk("no_grant_busy", 128'(busy), 128'(0));
      end
      clear_reqs();
      return;
    end
    exp_req.push_back('{tid: 2'(tid), addr: a});
    tick();
    clear_reqs();
    chk("issue_busy", 128'(busy), 128'(1));
    mem_req_ready = 1'b0;
    for (int i = 0; i < rdy_delay; i++) begin
      mem_rsp_valid = stray && (i == 0);
      mem_rsp_data  = {4{$urandom}};
      tick();
    end
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    repeat (rsp_delay) tick();
    d = {$urandom, $urandom, $urandom, $urandom};
    mem_rsp_data  = d;
    mem_rsp_valid = 1'b1;
    exp_rsp.push_back('{tid: 2'(tid), addr: a, line: d});
    tick();
    mem_rsp_valid = 1'b0;
    chk("rsp_strobe", 128'(l2_valid_rsp), 128'(1));
    tick();
    chk("back_to_idle", 128'(busy), 128'(0));
    chk("strobe_one_cycle", 128'(l2_valid_rsp), 128'(0));
  endtask

  function automatic logic [N*32-1:0] one_addr(input int t, input logic [31:0] a);
    logic [N*32-1:0] v;
    v = '0;
    v[32*t +: 32] = a;
    return v;
  endfunction

  initial begin
    logic [N*32-1:0] ad;
    bit found;
    int tid;
    logic [31:0] a;

    reset = 1'b1;
    clear_reqs();
    req_addr = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    tick(); tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Single refill from thread 2.
    run_txn(4'b0000, 4'b0100, 4'b0000, one_addr(2, 32'h0000_1238), 0, 1, 0);

    // Branch beats refill; refill thread follows on the next idle.
    ad = {4{$urandom}};
    run_txn(4'b0001, 4'b0010, 4'b0000, ad, 0, 0, 0);
    run_txn(4'b0000, 4'b0010, 4'b0000, ad, 1, 0, 0);

    // Reset while waiting for the response; a late response must be ignored.
    req_refill = 4'b0001; req_addr = {4{$urandom}};
    model_grant(br_req, req_refill, req_spec, req_addr, found, tid, a);
    exp_req.push_back('{tid: 2'(tid), addr: a});
    tick();
    clear_reqs();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("wait_busy", 128'(busy), 128'(1));
    reset = 1'b1;
    m_rr = 0;
    #1;
    check_all_zero("midwait_reset");
    tick();
    reset = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = {4{$urandom}};
    tick();
    mem_rsp_valid = 1'b0;
    check_all_zero("late_rsp");
    tick();
    check_all_zero("late_rsp2");

    // Round-robin across all four refill requesters: 0,1,2,3,0.
    for (int i = 0; i < 5; i++)
      run_txn(4'b0000, 4'b1111, 4'b0000, {4{$urandom}}, 0, 0, 0);

    // Backpressure for five cycles with a stray response during issue.
    run_txn(4'b0100, 4'b0000, 4'b0000, {4{$urandom}}, 5, 2, 1);

    // Next-line prefetch wrapping at the top of the address space.
    run_txn(4'b0000, 4'b0000, 4'b1000, one_addr(3, 32'hFFFF_FFFC), 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] br, rf, sp;
      br = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      rf = ($urandom_range(0, 1) == 0) ? N'($urandom) : '0;
      sp = N'($urandom);
      run_txn(br, rf, sp, {4{$urandom}}, $urandom_range(0, 3), $urandom_range(0, 3),
              1'($urandom_range(0, 1)));
    end

    tick(); tick();
    chk("req_queue_drained", 128'(exp_req.size()), 128'(0));
    chk("rsp_queue_drained", 128'(exp_rsp.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
